grn_clt: RTL
============

GRN_CLT -- requirements
Module: grn_clt

Interface
REQ-001 SHALL have parameter NLANES, default 12, number of uniform lanes summed (fixed at 12 for the 6.0 offset).
REQ-002 SHALL have parameter UBITS, default 12, uniform fraction width per lane.
REQ-003 SHALL have clk  input  1  rising-edge clock.
REQ-004 SHALL have nreset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have start  input  1  run request, sampled only in IDLE.
REQ-006 SHALL have ack  input  1  completion acknowledge, sampled only in DONE.
REQ-007 SHALL have seed  input  32  base seed, latched on start acceptance.
REQ-008 SHALL have niter  input  32  sample count, latched on start acceptance.
REQ-009 SHALL have grn_ready  input  1  downstream consumer ready.
REQ-010 SHALL have grn_valid  output  1  grn_dout holds a sample.
REQ-011 SHALL have grn_dout  output  32  Gaussian sample, signed two's complement, 17 integer / 15 fraction bits.
REQ-012 SHALL have busy  output  1  high in RUN.
REQ-013 SHALL have done  output  1  high in DONE.

Function
REQ-014 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start with niter!=0; IDLE->DONE on start with niter==0; RUN->DONE on the handshake of sample niter; DONE->IDLE on ack.
REQ-015 SHALL ignore start outside IDLE and ack outside DONE; start and ack together in IDLE: start wins.
REQ-016 SHALL, in the start-acceptance cycle T, load lane i LFSR (32-bit Galois, x^32+x^22+x^2+x+1) with seed XOR SEED_SALT[i]; a zero result is replaced by 32'h1.
REQ-017 SHALL advance each lane LFSR exactly 12 bit-steps per injection (unrolled, one clock).
REQ-018 SHALL inject one sample per cycle while in RUN, issued count < niter and pipeline not stalled; stage 1 registers u_i = LFSR_i[11:0].
REQ-019 SHALL compute stage 2: three partial sums of 4 lanes (14-bit); stage 3: total 16-bit unsigned; stage 4: (total - 24576) sign-extended and shifted left 3 into grn_dout.
REQ-020 SHALL carry a valid bit with each stage; first grn_valid at T+4 with grn_ready held high.
REQ-021 SHALL stall the whole pipeline and the LFSRs when grn_valid=1 and grn_ready=0; grn_dout and grn_valid SHALL then hold stable.
REQ-022 SHALL count a sample consumed only when grn_valid and grn_ready are both high; exactly niter samples emitted per run, no bubbles under constant ready.
REQ-023 SHALL keep grn_dout within [0xFFFD0000, 0x0002FFA0] (-6.0 to +5.99707).
REQ-024 SHALL deassert grn_valid in IDLE and DONE.

Reset
REQ-025 SHALL, on nreset low at any time including mid-run, asynchronously enter IDLE and clear LFSRs, counters, valid bits, grn_dout, grn_valid, busy, done to 0.
REQ-026 SHALL require a new start after reset; no partial run resumes.

Structure
REQ-027 SHALL place SEED_SALT[0..11], OFFSET_6 (24576), state encodings and widths in shared package bs_pkg.
REQ-028 SHALL use one sub-module, lfsr32_step12 (load, enable, 12-step advance), instantiated per lane.

Verification
REQ-029 SHALL test niter=0, start at T -> done=1 at T+1, grn_valid never high; ack -> IDLE next cycle.
REQ-030 SHALL test niter=5, ready=1 -> grn_valid T+4..T+8, busy falls and done rises at T+9, outputs match bit-exact reference model.
REQ-031 SHALL test niter=8, ready low 3 cycles at second sample -> grn_dout held, 8 unique handshakes, sequence identical to unstalled run.
REQ-032 SHALL test seed forcing a lane to zero (seed=SEED_SALT[3]) -> lane 3 loaded 32'h1, output matches model.
REQ-033 SHALL test nreset low mid-run at sample 3 of 10 -> all outputs 0 immediately; fresh start reproduces same first sample.
REQ-034 SHALL test 100000 samples, random ready -> all within REQ-023 range, mean |x|<0.02, variance 1.0+/-0.02.

Source files
------------

// File: rtl/bs_pkg.sv
// bs_pkg: shared constants, state encoding and widths for the grn_clt Gaussian generator
package bs_pkg;
  localparam int LANES = 12;
  localparam int UW = 12;
  localparam int PSW = UW + 2;
  localparam int TOTW = UW + 4;
  localparam int OFFSET_6 = 24576;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [0:LANES-1][31:0] SEED_SALT = {
    32'h9E37_79B9, 32'h7F4A_7C15, 32'hF39C_C060, 32'h5CED_C834,
    32'h2545_F491, 32'hA5A5_A5A5, 32'h3C6E_F372, 32'hBB67_AE85,
    32'h510E_527F, 32'h9B05_688C, 32'h1F83_D9AB, 32'h5BE0_CD19
  };
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? (s >> 1) ^ LFSR_TAPS : s >> 1;
  endfunction
endpackage

// File: rtl/lfsr32_step12.sv
// lfsr32_step12: one lane's 32-bit Galois LFSR advanced 12 bit-steps per enabled clock
//   clk, nreset : clock, async active-low reset
//   load, seed  : load seed (zero replaced by 1, the LFSR lock-up state)
//   en          : advance 12 steps
//   u           : low OBITS bits of the current state
module lfsr32_step12 import bs_pkg::*; #(
  parameter int OBITS = 12
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             load,
  input  logic             en,
  input  logic [31:0]      seed,
  output logic [OBITS-1:0] u
);
  logic [31:0] s, s_adv;
  always_comb begin
    s_adv = s;
    for (int k = 0; k < 12; k++) s_adv = lfsr_step(s_adv);
  end
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) s <= '0;
    else if (load) s <= (seed == '0) ? 32'h1 : seed;
    else if (en) s <= s_adv;
  assign u = s[OBITS-1:0];
endmodule

// File: rtl/grn_clt.sv
// grn_clt: central-limit Gaussian sample generator (sum of 12 uniforms minus 6.0)
//   clk, nreset          : clock, async active-low reset
//   start, seed, niter   : run request with base seed and sample count (IDLE only)
//   ack                  : completion acknowledge (DONE only)
//   grn_valid, grn_ready : output handshake
//   grn_dout             : signed 17.15 sample
//   busy, done           : RUN / DONE status
module grn_clt import bs_pkg::*; #(
  parameter int NLANES = 12,
  parameter int UBITS = 12
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        start,
  input  logic        ack,
  input  logic [31:0] seed,
  input  logic [31:0] niter,
  input  logic        grn_ready,
  output logic        grn_valid,
  output logic [31:0] grn_dout,
  output logic        busy,
  output logic        done
);
  localparam int PW = UBITS + 2;
  localparam int TW = UBITS + 4;
  state_t state, state_nxt;
  logic [31:0] niter_q, issued, consumed;
  logic [UBITS-1:0] u [NLANES];
  logic [PW-1:0] ps [3];
  logic [TW-1:0] total;
  logic v2, v3, accept, stall, hs, inject;
  assign accept = state == IDLE && start;
  assign stall = grn_valid && !grn_ready;
  assign hs = grn_valid && grn_ready;
  // The LFSR registers act as pipeline stage 1: they hold the next sample's uniforms.
  assign inject = state == RUN && issued != niter_q && !stall;
  assign busy = state == RUN;
  assign done = state == DONE;
  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    lfsr32_step12 #(.OBITS(UBITS)) u_lfsr (
      .clk(clk), .nreset(nreset), .load(accept), .en(inject),
      .seed(seed ^ SEED_SALT[i]), .u(u[i])
    );
  end
  always_comb begin
    state_nxt = state;
    if (state == IDLE && start) state_nxt = (niter == '0) ? DONE : RUN;
    else if (state == RUN && hs && consumed == niter_q - 32'd1) state_nxt = DONE;
    else if (state == DONE && ack) state_nxt = IDLE;
  end
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      state <= IDLE;
      niter_q <= '0;
      issued <= '0;
      consumed <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        niter_q <= niter;
        issued <= '0;
        consumed <= '0;
      end else begin
        if (inject) issued <= issued + 32'd1;
        if (hs) consumed <= consumed + 32'd1;
      end
    end
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      for (int g = 0; g < 3; g++) ps[g] <= '0;
      total <= '0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      grn_valid <= 1'b0;
      grn_dout <= '0;
    end else if (!stall) begin
      for (int g = 0; g < 3; g++)
        ps[g] <= PW'(u[4*g]) + PW'(u[4*g+1]) + PW'(u[4*g+2]) + PW'(u[4*g+3]);
      v2 <= inject;
      total <= TW'(ps[0]) + TW'(ps[1]) + TW'(ps[2]);
      v3 <= v2;
      grn_dout <= (32'(total) - 32'(OFFSET_6)) << 3;
      grn_valid <= v3;
    end
endmodule
